// File: rtl/dense_layer01.sv
// Fully connected layer: LAYER parallel MAC lanes step through N_IN inputs,
// then rescale by FRAC and saturate each neuron to W bits for the ReLU stage.
module dense_layer01 #(
  parameter int W     = 8,
  parameter int N_IN  = 16,
  parameter int LAYER = 10,
  parameter int ACC_W = 24,
  parameter int FRAC  = 4,
  localparam int AW   = $clog2(N_IN*LAYER + LAYER)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic [N_IN*W-1:0]    data_in,
  output logic                 ready_in,
  input  logic                 wt_we,
  input  logic [AW-1:0]        wt_addr,
  input  logic [W-1:0]         wt_data,
  output logic                 valid_out,
  output logic [LAYER*W-1:0]   data_out
);

  localparam int NW = N_IN*LAYER + LAYER;
  localparam int IW = $clog2(N_IN);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic signed [W-1:0]     MAX_W   = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]     MIN_W   = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t                  state_q;
  logic [IW-1:0]           idx_q;
  logic signed [W-1:0]     x_q   [N_IN];
  logic signed [W-1:0]     wt_q  [NW];
  logic signed [ACC_W-1:0] acc_q [LAYER];
  logic [LAYER*W-1:0]      data_out_q;
  logic                    valid_out_q;

  logic                    wr_en;
  logic signed [2*W-1:0]   prod    [LAYER];
  logic signed [W-1:0]     bias_w  [LAYER];
  logic signed [ACC_W-1:0] shifted [LAYER];
  logic signed [W-1:0]     sat_v   [LAYER];

  assign wr_en = wt_we && (state_q == S_IDLE) && ({1'b0, wt_addr} < (AW+1)'(NW));

  // Bias is forwarded from the write port so a write on the capture edge is seen by the frame.
  always_comb begin
    for (int n = 0; n < LAYER; n++) begin
      prod[n]    = x_q[idx_q] * wt_q[AW'(n*N_IN) + AW'(idx_q)];
      bias_w[n]  = (wr_en && (wt_addr == AW'(N_IN*LAYER + n))) ? wt_data
                                                               : wt_q[AW'(N_IN*LAYER + n)];
      shifted[n] = acc_q[n] >>> FRAC;
      if (shifted[n] > SAT_MAX)      sat_v[n] = MAX_W;
      else if (shifted[n] < SAT_MIN) sat_v[n] = MIN_W;
      else                           sat_v[n] = shifted[n][W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
      for (int j = 0; j < N_IN; j++)  x_q[j]   <= '0;
      for (int i = 0; i < NW; i++)    wt_q[i]  <= '0;
      for (int n = 0; n < LAYER; n++) acc_q[n] <= '0;
    end else begin
      valid_out_q <= 1'b0;
      if (wr_en) wt_q[wt_addr] <= wt_data;
      case (state_q)
        S_IDLE: begin
          if (valid_in) begin
            for (int j = 0; j < N_IN; j++) x_q[j] <= data_in[j*W +: W];
            for (int n = 0; n < LAYER; n++)
              acc_q[n] <= {{(ACC_W-W){bias_w[n][W-1]}}, bias_w[n]} << FRAC;
            idx_q   <= '0;
            state_q <= S_MAC;
          end
        end
        S_MAC: begin
          for (int n = 0; n < LAYER; n++)
            acc_q[n] <= acc_q[n] + {{(ACC_W-2*W){prod[n][2*W-1]}}, prod[n]};
          idx_q <= idx_q + IW'(1);
          if (idx_q == IW'(N_IN-1)) state_q <= S_OUT;
        end
        S_OUT: begin
          for (int n = 0; n < LAYER; n++) data_out_q[n*W +: W] <= sat_v[n];
          valid_out_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready_in  = (state_q == S_IDLE);
  assign valid_out = valid_out_q;
  assign data_out  = data_out_q;

endmodule

// File: tb/tb_dense_layer01.sv
// Bench for dense_layer01: integer reference model feeds a scoreboard queue
// that is checked against each valid_out pulse.
module tb_dense_layer01;
  localparam int W = 8, N_IN = 16, LAYER = 10, ACC_W = 24, FRAC = 4;
  localparam int NW = N_IN*LAYER + LAYER;
  localparam int AW = $clog2(NW);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 valid_in;
  logic [N_IN*W-1:0]    data_in;
  logic                 ready_in;
  logic                 wt_we;
  logic [AW-1:0]        wt_addr;
  logic [W-1:0]         wt_data;
  logic                 valid_out;
  logic [LAYER*W-1:0]   data_out;

  dense_layer01 #(.W(W), .N_IN(N_IN), .LAYER(LAYER), .ACC_W(ACC_W), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in), .ready_in(ready_in),
    .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
    .valid_out(valid_out), .data_out(data_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int acc_cyc = 0;
  int m_w [LAYER][N_IN];
  int m_b [LAYER];
  logic [LAYER*W-1:0] sb [$];

  function automatic logic [LAYER*W-1:0] model(input logic [N_IN*W-1:0] x);
    logic [LAYER*W-1:0] r;
    int acc, s;
    r = '0;
    for (int n = 0; n < LAYER; n++) begin
      acc = m_b[n] * (1 << FRAC);
      for (int j = 0; j < N_IN; j++) acc += int'($signed(x[j*W +: W])) * m_w[n][j];
      s = acc >>> FRAC;
      if (s > 127) s = 127;
      if (s < -128) s = -128;
      r[n*W +: W] = s[W-1:0];
    end
    return r;
  endfunction

  function automatic void model_clear();
    for (int n = 0; n < LAYER; n++) begin
      m_b[n] = 0;
      for (int j = 0; j < N_IN; j++) m_w[n][j] = 0;
    end
  endfunction

  function automatic void model_write(input int addr, input int val);
    if (addr < N_IN*LAYER) m_w[addr / N_IN][addr % N_IN] = val;
    else if (addr < NW)    m_b[addr - N_IN*LAYER] = val;
  endfunction

  task automatic write_wt(input int addr, input int val);
    wt_we = 1'b1; wt_addr = AW'(addr); wt_data = W'(val);
    @(posedge clk); #1;
    wt_we = 1'b0;
    model_write(addr, val);
  endtask

  task automatic accept_frame(input logic [N_IN*W-1:0] x);
    for (int k = 0; k < 40 && ready_in !== 1'b1; k++) begin @(posedge clk); #1; end
    checks++;
    if (ready_in !== 1'b1) begin
      failures++; $display("FAIL accept_ready got=%b want=1", ready_in);
    end
    valid_in = 1'b1; data_in = x;
    sb.push_back(model(x));
    @(posedge clk); #1;
    valid_in = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_output(input string name);
    logic [LAYER*W-1:0] exp, held;
    bit got = 0;
    for (int k = 0; k < 60; k++) begin
      if (valid_out === 1'b1) begin got = 1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!got) begin
      failures++; $display("FAIL %s_timeout got=no valid_out want=valid_out", name);
      return;
    end
    if (sb.size() == 0) begin
      failures++; $display("FAIL %s_unexpected got=valid_out want=empty scoreboard", name);
      return;
    end
    exp = sb.pop_front();
    if (data_out !== exp) begin
      failures++; $display("FAIL %s_data got=%h want=%h", name, data_out, exp);
    end
    checks++;
    if (cyc - acc_cyc != N_IN + 1) begin
      failures++; $display("FAIL %s_latency got=%0d want=%0d", name, cyc - acc_cyc, N_IN + 1);
    end
    held = data_out;
    @(posedge clk); #1;
    checks++;
    if (valid_out !== 1'b0 || data_out !== held) begin
      failures++; $display("FAIL %s_pulse got=%b/%h want=0/%h", name, valid_out, data_out, held);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (valid_out !== 1'b0 || data_out !== '0 || ready_in !== 1'b1) begin
      failures++; $display("FAIL reset_state got=v%b d%h r%b want=v0 d0 r1", valid_out, data_out, ready_in);
    end
  endtask

  task automatic test_bias_only();
    logic [N_IN*W-1:0] x;
    int low;
    logic [LAYER*W-1:0] want;
    for (int n = 0; n < LAYER; n++) write_wt(N_IN*LAYER + n, n - 5);
    for (int n = 0; n < LAYER; n++) want[n*W +: W] = 8'(n - 5);
    x = {$urandom(), $urandom(), $urandom(), $urandom()};
    accept_frame(x);
    low = 0;
    for (int k = 0; k < 40; k++) begin
      if (ready_in === 1'b0) low++; else break;
      @(posedge clk); #1;
    end
    checks++;
    if (low != N_IN + 1) begin
      failures++; $display("FAIL bias_ready_low got=%0d want=%0d", low, N_IN + 1);
    end
    checks++;
    if (data_out !== want) begin
      failures++; $display("FAIL bias_const got=%h want=%h", data_out, want);
    end
    wait_output("bias");
  endtask

  task automatic test_identity();
    logic [N_IN*W-1:0] x;
    for (int n = 0; n < LAYER; n++) write_wt(N_IN*LAYER + n, 0);
    for (int n = 0; n < LAYER; n++) write_wt(n*N_IN + n, 16);
    write_wt(NW + 5, 99);
    for (int j = 0; j < N_IN; j++) x[j*W +: W] = 8'(3*j - 20);
    accept_frame(x);
    wait_output("identity");
  endtask

  task automatic test_saturation();
    logic [N_IN*W-1:0] x;
    for (int a = 0; a < N_IN*LAYER; a++) write_wt(a, 127);
    x = {N_IN{8'sd127}};
    accept_frame(x);
    wait_output("sat_pos");
    checks++;
    if (data_out !== {LAYER{8'h7f}}) begin
      failures++; $display("FAIL sat_pos_const got=%h want=all 7f", data_out);
    end
    x = {N_IN{8'h80}};
    accept_frame(x);
    wait_output("sat_neg");
    checks++;
    if (data_out !== {LAYER{8'h80}}) begin
      failures++; $display("FAIL sat_neg_const got=%h want=all 80", data_out);
    end
  endtask

  task automatic test_back_to_back();
    int acc_n = 0, last_acc = -1;
    logic [LAYER*W-1:0] exp;
    for (int a = 0; a < NW; a++) write_wt(a, int'($urandom_range(255)) - 128);
    for (int c = 0; c < 75; c++) begin
      if (valid_out === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL b2b_unexpected got=valid_out want=empty scoreboard");
        end else begin
          exp = sb.pop_front();
          if (data_out !== exp) begin
            failures++; $display("FAIL b2b_data got=%h want=%h", data_out, exp);
          end
        end
      end
      data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      valid_in = 1'b1;
      if (ready_in === 1'b1) begin
        sb.push_back(model(data_in));
        if (last_acc >= 0) begin
          checks++;
          if (cyc + 1 - last_acc != N_IN + 2) begin
            failures++; $display("FAIL b2b_spacing got=%0d want=%0d", cyc + 1 - last_acc, N_IN + 2);
          end
        end
        last_acc = cyc + 1;
        acc_cyc = cyc + 1;
        acc_n++;
      end
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    checks++;
    if (acc_n != 5) begin
      failures++; $display("FAIL b2b_accepts got=%0d want=5", acc_n);
    end
    for (int k = 0; k < 3 && sb.size() > 0; k++) wait_output("b2b_drain");
  endtask

  task automatic test_reset_mid_frame();
    logic [N_IN*W-1:0] x;
    int seen = 0;
    x = {$urandom(), $urandom(), $urandom(), $urandom()};
    accept_frame(x);
    void'(sb.pop_back());
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    checks++;
    if (valid_out !== 1'b0 || data_out !== '0 || ready_in !== 1'b1) begin
      failures++; $display("FAIL midrst_async got=v%b d%h r%b want=v0 d0 r1", valid_out, data_out, ready_in);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
    for (int k = 0; k < 25; k++) begin
      if (valid_out === 1'b1) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0 || ready_in !== 1'b1 || data_out !== '0) begin
      failures++; $display("FAIL midrst_quiet got=pulses%0d r%b d%h want=0 1 0", seen, ready_in, data_out);
    end
    accept_frame({N_IN{8'h7f}});
    wait_output("midrst_zero");
    checks++;
    if (data_out !== '0) begin
      failures++; $display("FAIL midrst_weights got=%h want=0", data_out);
    end
  endtask

  task automatic test_busy_write();
    logic [N_IN*W-1:0] x;
    for (int f = 0; f < 2; f++) begin
      x = {$urandom(), $urandom(), $urandom(), $urandom()};
      x[W-1:0] = 8'd5;
      accept_frame(x);
      if (f == 0) begin
        repeat (3) begin @(posedge clk); #1; end
        wt_we = 1'b1; wt_addr = '0; wt_data = 8'd16;
        @(posedge clk); #1;
        wt_we = 1'b0;
      end
      wait_output("busy");
      checks++;
      if (data_out[W-1:0] !== 8'd0) begin
        failures++; $display("FAIL busy_n0_f%0d got=%0d want=0", f, $signed(data_out[W-1:0]));
      end
    end
  endtask

  task automatic test_write_on_capture();
    logic [N_IN*W-1:0] x;
    x = {$urandom(), $urandom(), $urandom(), $urandom()};
    model_write(N_IN*LAYER + 3, 9);
    wt_we = 1'b1; wt_addr = AW'(N_IN*LAYER + 3); wt_data = 8'd9;
    accept_frame(x);
    wt_we = 1'b0;
    wait_output("cap_bias");
    x[W-1:0] = 8'd4;
    model_write(2*N_IN, 32);
    wt_we = 1'b1; wt_addr = AW'(2*N_IN); wt_data = 8'd32;
    accept_frame(x);
    wt_we = 1'b0;
    wait_output("cap_weight");
    checks++;
    if (data_out[2*W +: W] !== 8'd8) begin
      failures++; $display("FAIL cap_weight_n2 got=%0d want=8", $signed(data_out[2*W +: W]));
    end
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; data_in = '0; wt_we = 1'b0; wt_addr = '0; wt_data = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_bias_only();
    test_identity();
    test_saturation();
    test_back_to_back();
    test_reset_mid_frame();
    test_busy_write();
    test_write_on_capture();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
